// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: clock-enable prescaler, x/y raster counters and registered sync/active decodes.
// Optional frame counter built only when VGA_FRAME_CNT_EN is defined; otherwise frame_cnt is tied to zero.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_cfg
            $error("vga_timing_gen: illegal timing configuration");
        end
    endgenerate

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] X_HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] X_HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] Y_VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] Y_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0]  div_cnt;
    logic        advance;
    logic        x_wrap;
    logic        y_wrap;
    logic [9:0]  x_nxt;
    logic [9:0]  y_nxt;
    logic [10:0] xn;
    logic [10:0] yn;

    // Decodes are taken from the next position so they land in the same register stage as x/y.
    always_comb begin
        advance = (div_cnt == DIV_LAST);
        x_wrap  = (x == X_LAST);
        y_wrap  = (y == Y_LAST);
        x_nxt   = x_wrap ? '0 : x + 10'd1;
        y_nxt   = y;
        if (x_wrap) begin
            y_nxt = y_wrap ? '0 : y + 10'd1;
        end
        xn = {1'b0, x_nxt};
        yn = {1'b0, y_nxt};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            pix_en      <= 1'b0;
            x           <= X_LAST;
            y           <= Y_LAST;
            active      <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en  <= advance;
            div_cnt <= advance ? '0 : div_cnt + 4'd1;
            if (advance) begin
                x           <= x_nxt;
                y           <= y_nxt;
                active      <= (xn < X_ACT) && (yn < Y_ACT);
                hsync       <= (xn >= X_HS_BEG && xn < X_HS_END) ? SYNC_POL : ~SYNC_POL;
                vsync       <= (yn >= Y_VS_BEG && yn < Y_VS_END) ? SYNC_POL : ~SYNC_POL;
                line_start  <= (x_nxt == '0);
                frame_start <= (x_nxt == '0) && (y_nxt == '0);
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Starts at 8'hFF so the wrap into the first frame after reset reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '1;
        end else if (advance && x_wrap && y_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances with different timings checked every clock against
// a model that derives expected outputs from the number of clocks since reset release.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       line_start;
        logic       frame_start;
        logic [7:0] frame_cnt;
    } obs_t;

`ifdef VGA_FRAME_CNT_EN
    localparam bit FC_ON = 1'b1;
`else
    localparam bit FC_ON = 1'b0;
`endif
    localparam logic [7:0] FC_RST = FC_ON ? 8'hFF : 8'h00;

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    int   n_a = 0, n_b = 0, n_c = 0;
    int   vec = 0, bad = 0;

    always #10 clk = ~clk;

    // Clocks since the last edge that sampled reset high.
    always @(posedge clk) begin
        n_a <= rst_a ? 0 : n_a + 1;
        n_b <= rst_b ? 0 : n_b + 1;
        n_c <= rst_c ? 0 : n_c + 1;
    end

    logic       a_pe, a_act, a_hs, a_vs, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic [7:0] a_fc;
    logic       b_pe, b_act, b_hs, b_vs, b_ls, b_fs;
    logic [9:0] b_x, b_y;
    logic [7:0] b_fc;
    logic       c_pe, c_act, c_hs, c_vs, c_ls, c_fs;
    logic [9:0] c_x, c_y;
    logic [7:0] c_fc;
    obs_t       obs_a, obs_b, obs_c;

    assign obs_a = {a_pe, a_x, a_y, a_act, a_hs, a_vs, a_ls, a_fs, a_fc};
    assign obs_b = {b_pe, b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs, b_fc};
    assign obs_c = {c_pe, c_x, c_y, c_act, c_hs, c_vs, c_ls, c_fs, c_fc};

    vga_timing_gen #(.CLK_DIV(2)) u_a (
        .clk(clk), .reset(rst_a), .pix_en(a_pe), .x(a_x), .y(a_y), .active(a_act),
        .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_b (
        .clk(clk), .reset(rst_b), .pix_en(b_pe), .x(b_x), .y(b_y), .active(b_act),
        .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(3), .V_FP(2), .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b0)
    ) u_c (
        .clk(clk), .reset(rst_c), .pix_en(c_pe), .x(c_x), .y(c_y), .active(c_act),
        .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc)
    );

    // Pixel k (0-based) is presented after clock (k+1)*cd; before the first advance the reset values hold.
    function automatic obs_t model(input int n, input int cd, input int ha, input int hfp, input int hs,
                                   input int hbp, input int va, input int vfp, input int vs, input int vbp,
                                   input bit pol);
        obs_t o;
        int ht, vt, k, p, xi, yi, f;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        k  = n / cd;
        if (k == 0) begin
            o = '{pix_en: 1'b0, x: 10'(ht - 1), y: 10'(vt - 1), active: 1'b0, hsync: !pol, vsync: !pol,
                  line_start: 1'b0, frame_start: 1'b0, frame_cnt: FC_RST};
        end else begin
            p  = k - 1;
            xi = p % ht;
            yi = (p / ht) % vt;
            f  = p / (ht * vt);
            o.pix_en      = ((n % cd) == 0);
            o.x           = 10'(xi);
            o.y           = 10'(yi);
            o.active      = (xi < ha) && (yi < va);
            o.hsync       = (xi >= ha + hfp && xi < ha + hfp + hs) ? pol : !pol;
            o.vsync       = (yi >= va + vfp && yi < va + vfp + vs) ? pol : !pol;
            o.line_start  = (xi == 0);
            o.frame_start = (xi == 0) && (yi == 0);
            o.frame_cnt   = FC_ON ? 8'(f % 256) : 8'h00;
        end
        return o;
    endfunction

    function automatic obs_t exp_a(input int n);
        return model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    endfunction
    function automatic obs_t exp_b(input int n);
        return model(n, 1, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1);
    endfunction
    function automatic obs_t exp_c(input int n);
        return model(n, 3, 6, 1, 2, 3, 3, 2, 1, 2, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++;
            if (obs_a.x !== 10'd799 || obs_a.y !== 10'd524 || obs_a.pix_en !== 1'b0 || obs_a.hsync !== 1'b1 ||
                obs_a.vsync !== 1'b1 || obs_a.active !== 1'b0 || obs_a.frame_cnt !== FC_RST) begin
                bad++;
                $display("FAIL reset_a cyc=%0d got=%h exp x=799 y=524 pe=0 hs=1 vs=1 act=0 fc=%h", i, obs_a, FC_RST);
            end
            vec++;
            if (obs_b !== exp_b(0) || obs_c !== exp_c(0)) begin
                bad++;
                $display("FAIL reset_bc cyc=%0d got b=%h c=%h exp b=%h c=%h", i, obs_b, obs_c, exp_b(0), exp_c(0));
            end
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
    endtask

    task automatic test_startup();
        logic       pe_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [9:0] x_t  [4] = '{10'd799, 10'd0, 10'd0, 10'd1};
        logic [9:0] y_t  [4] = '{10'd524, 10'd0, 10'd0, 10'd0};
        logic       act_t[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       fs_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            tick();
            vec++;
            if (obs_a.pix_en !== pe_t[i] || obs_a.x !== x_t[i] || obs_a.y !== y_t[i] || obs_a.active !== act_t[i] ||
                obs_a.frame_start !== fs_t[i] || obs_a.line_start !== fs_t[i]) begin
                bad++;
                $display("FAIL startup_a clk=%0d got pe=%b x=%0d y=%0d act=%b fs=%b ls=%b exp pe=%b x=%0d y=%0d act=%b fs=ls=%b",
                         i + 1, obs_a.pix_en, obs_a.x, obs_a.y, obs_a.active, obs_a.frame_start, obs_a.line_start,
                         pe_t[i], x_t[i], y_t[i], act_t[i], fs_t[i]);
            end
            vec++;
            if (obs_b !== exp_b(n_b) || obs_c !== exp_c(n_c)) begin
                bad++;
                $display("FAIL startup_bc n=%0d got b=%h c=%h exp b=%h c=%h", n_b, obs_b, obs_c, exp_b(n_b), exp_c(n_c));
            end
        end
    endtask

    task automatic test_line();
        int hs_cnt = 0, inact = 0, hs_min = 9999, hs_max = -1;
        int last_x = -1, last_y = -1;
        bit saw_wrap = 1'b0;
        while (n_a < 1604) begin
            tick();
            vec++;
            if (obs_a !== exp_a(n_a)) begin
                bad++;
                $display("FAIL line_a n=%0d got=%h exp=%h", n_a, obs_a, exp_a(n_a));
            end
            if (obs_a.pix_en === 1'b1) begin
                if (obs_a.y === 10'd0 && obs_a.hsync === 1'b0) begin
                    hs_cnt++;
                    if (int'(obs_a.x) < hs_min) hs_min = int'(obs_a.x);
                    if (int'(obs_a.x) > hs_max) hs_max = int'(obs_a.x);
                end
                if (obs_a.y === 10'd0 && obs_a.active === 1'b0) inact++;
                if (obs_a.x === 10'd0 && obs_a.y === 10'd1) begin
                    saw_wrap = 1'b1;
                    vec++;
                    if (last_x != 799 || last_y != 0) begin
                        bad++;
                        $display("FAIL line_wrap prev got x=%0d y=%0d exp x=799 y=0", last_x, last_y);
                    end
                end
                last_x = int'(obs_a.x);
                last_y = int'(obs_a.y);
            end
        end
        vec++;
        if (hs_cnt != 96 || hs_min != 656 || hs_max != 751 || inact != 160 || !saw_wrap) begin
            bad++;
            $display("FAIL line_stats got hs=%0d x=%0d..%0d inactive=%0d wrap=%b exp hs=96 x=656..751 inactive=160 wrap=1",
                     hs_cnt, hs_min, hs_max, inact, saw_wrap);
        end
    endtask

    task automatic test_frame();
        int frames = 0, vs_cnt = 0, last_fs = -1;
        logic [7:0] fc_exp;
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        vec++;
        if (obs_b !== exp_b(0)) begin
            bad++;
            $display("FAIL frame_reset_b got=%h exp=%h", obs_b, exp_b(0));
        end
        for (int i = 0; i < 258 * 120; i++) begin
            tick();
            vec++;
            if (obs_b !== exp_b(n_b) || obs_c !== exp_c(n_c)) begin
                bad++;
                $display("FAIL frame_bc n=%0d got b=%h c=%h exp b=%h c=%h", n_b, obs_b, obs_c, exp_b(n_b), exp_c(n_c));
            end
            if (obs_b.frame_start === 1'b1) begin
                frames++;
                if (last_fs >= 0) begin
                    vec++;
                    if (n_b - last_fs != 120) begin
                        bad++;
                        $display("FAIL frame_period got=%0d exp=120", n_b - last_fs);
                    end
                end
                last_fs = n_b;
                if (frames == 1 || frames == 256 || frames == 257) begin
                    fc_exp = FC_ON ? ((frames == 256) ? 8'd255 : 8'd0) : 8'd0;
                    vec++;
                    if (obs_b.frame_cnt !== fc_exp) begin
                        bad++;
                        $display("FAIL frame_cnt frame=%0d got=%0d exp=%0d", frames, obs_b.frame_cnt, fc_exp);
                    end
                end
            end
            if (frames == 1 && obs_b.vsync === 1'b1) vs_cnt++;
        end
        vec++;
        if (vs_cnt != 30 || frames != 258) begin
            bad++;
            $display("FAIL frame_stats got vsync_strobes=%0d frames=%0d exp 30 and 258", vs_cnt, frames);
        end
    endtask

    task automatic test_back_to_back();
        int run, hold, tgt;
        for (int it = 0; it < 24; it++) begin
            run  = (it == 0) ? 1700 : int'($urandom_range(1, 600));
            hold = int'($urandom_range(1, 3));
            tgt  = int'($urandom_range(0, 2));
            for (int i = 0; i < run + hold; i++) begin
                if (i == run) begin
                    rst_a = (tgt == 0);
                    rst_b = (tgt == 1);
                    rst_c = (tgt == 2);
                end
                tick();
                vec++;
                if (obs_a !== exp_a(n_a) || obs_b !== exp_b(n_b) || obs_c !== exp_c(n_c)) begin
                    bad++;
                    $display("FAIL b2b it=%0d n=%0d/%0d/%0d got a=%h b=%h c=%h exp a=%h b=%h c=%h", it, n_a, n_b, n_c,
                             obs_a, obs_b, obs_c, exp_a(n_a), exp_b(n_b), exp_c(n_c));
                end
            end
            rst_a = 1'b0;
            rst_b = 1'b0;
            rst_c = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_line();
        test_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
